wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback arbiter feeding the single write port of the 32x32 register file.
//   Merges the in-order ALU/pipeline writeback (priority, never back-pressured)
//   with out-of-order load/long-latency results buffered in a small FIFO.
//   Enforces WAW order between the two sources, bounds FIFO starvation by
//   stalling the pipeline, and reports per-register pending status for hazard
//   detection in decode.
// PARAMETERS
//   DEPTH      4   load FIFO entries; power of 2, >= 2
//   STARVE_MAX 8   consecutive cycles a non-empty FIFO may be bypassed before a forced drain
// PORTS
//   clk         in   1   clock; all state updates on posedge
//   rst_n       in   1   asynchronous, active-low reset
//   alu_we      in   1   pipeline writeback valid
//   alu_wa      in   5   pipeline writeback address
//   alu_wd      in   32  pipeline writeback data
//   pipe_stall  out  1   pipeline must hold; alu_* ignored this cycle and re-presented next
//   ld_valid    in   1   load result valid
//   ld_ready    out  1   FIFO can accept; push when ld_valid && ld_ready
//   ld_wa       in   5   load destination address
//   ld_wd       in   32  load data
//   wb_we       out  1   regfile write enable (registered)
//   wb_wa       out  5   regfile write address (registered)
//   wb_wd       out  32  regfile write data (registered)
//   qa1, qa2    in   5   decode query addresses
//   q_busy1/2   out  1   queried register has a write not yet committed to regfile
//   fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//   Reset (rst_n=0, takes effect immediately): wb_we=0, wb_wa=0, wb_wd=0, FIFO empty,
//     all kill bits 0, starve_cnt=0, pipe_stall=0, ld_ready=1, fifo_count=0.
//     Reset mid-operation discards buffered loads; no write is issued for them.
//   Latency: the selected source appears on wb_* the cycle after selection (1 cycle).
//   Selection each cycle (in priority order):
//     1. pipe_stall=1 (starve_cnt==STARVE_MAX, FIFO non-empty): pop FIFO head.
//     2. alu_we=1 and alu_wa!=0: issue ALU write.
//     3. FIFO non-empty: pop FIFO head.
//     4. Otherwise: wb_we<=0.
//   A popped entry with kill=1 is discarded: wb_we<=0, FIFO still pops.
//   An ALU write with alu_wa=0 is treated as no write; the FIFO may drain that cycle.
//   pipe_stall: combinational, = (starve_cnt==STARVE_MAX) && fifo_count!=0.
//   starve_cnt: cleared on any pop or when the FIFO is empty; otherwise +1,
//     saturating at STARVE_MAX.
//   FIFO push: ld_valid && ld_ready. ld_ready = (fifo_count != DEPTH), counted
//     before this cycle's pop; a full FIFO does not accept in the same cycle as a pop.
//     A push with ld_wa=0 is accepted and dropped (not enqueued).
//   Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
//   WAW ordering: an issued ALU write sets kill on every valid FIFO entry whose
//     wa==alu_wa. A load pushed in the same cycle is newer and is not killed.
//   q_busyN = (qaN!=0) && ((any valid, unkilled entry with wa==qaN) ||
//     (wb_we && wb_wa==qaN)). Combinational. Excludes the alu_* inputs.
// TESTING
//   Idle, ld push wa=5 wd=0xAAAA_0001 -> next cycle wb_we=1 wa=5 wd=0xAAAA_0001; fifo_count 1->0.
//   alu_we=1 on every cycle, 3 loads pushed -> loads held; pipe_stall=1 on the 9th bypassed cycle; head drains then; FIFO empties after 3 stalls.
//   Fill 4 loads while the ALU blocks -> ld_ready=0 at count 4; a 5th ld_valid is not accepted; ld_ready=1 the cycle after the first pop.
//   Load wa=7 buffered, then ALU writes wa=7 wd=0x11 -> load popped with wb_we=0; regfile x7 ends at 0x11; q_busy(7) drops after the ALU commit.
//   Load to wa=0 and ALU to wa=0 -> no write issued, fifo_count stays 0, q_busy(0)=0.
//   rst_n low with 3 entries queued -> wb_we=0 immediately, fifo_count=0; no write to the queued addresses after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
//   Bundles the pipeline writeback, load-result, regfile-write and decode-query
//   signals of the writeback arbiter.
//   master : the surrounding core. It drives alu_*, ld_valid/ld_wa/ld_wd and
//            qa1/qa2, and observes everything else.
//   slave  : the arbiter itself.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          alu_we;
   logic [4:0]    alu_wa;
   logic [31:0]   alu_wd;
   logic          pipe_stall;
   logic          ld_valid;
   logic          ld_ready;
   logic [4:0]    ld_wa;
   logic [31:0]   ld_wd;
   logic          wb_we;
   logic [4:0]    wb_wa;
   logic [31:0]   wb_wd;
   logic [4:0]    qa1;
   logic [4:0]    qa2;
   logic          q_busy1;
   logic          q_busy2;
   logic [CW-1:0] fifo_count;

   modport master (
      output alu_we, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, qa1, qa2,
      input  pipe_stall, ld_ready, wb_we, wb_wa, wb_wd, q_busy1, q_busy2, fifo_count
   );

   modport slave (
      input  alu_we, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, qa1, qa2,
      output pipe_stall, ld_ready, wb_we, wb_wa, wb_wd, q_busy1, q_busy2, fifo_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Drives the single write port of the 32x32 register file. It merges two
//   sources:
//     - the in-order ALU/pipeline writeback, which has priority and is never
//       back-pressured except through pipe_stall;
//     - out-of-order load results, which are buffered in a DEPTH-entry FIFO.
//   The FIFO head is forced out (with the pipeline stalled) after STARVE_MAX
//   consecutive bypassed cycles. Buffered loads that an ALU write to the same
//   register overtakes are marked killed, and they are dropped when popped
//   (WAW order). q_busy1/2 report registers whose writes have not reached the
//   regfile yet.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : wb_arbiter_if.slave
//            alu_* in, pipe_stall out, ld_* in / ld_ready out,
//            wb_* out (registered), qa1/qa2 in, q_busy1/2 out, fifo_count out
// ---------------------------------------------------------------------------
module wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   // FIFO storage. The payload is not reset; valid entries are derived from the pointers.
   logic [4:0]       wa_q [DEPTH];
   logic [31:0]      wd_q [DEPTH];
   logic [DEPTH-1:0] kill_q;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;

   logic             wb_we_q, wb_we_d;
   logic [4:0]       wb_wa_q, wb_wa_d;
   logic [31:0]      wb_wd_q, wb_wd_d;

   logic             fifo_ne, stall, alu_ok, pop, push_acc, push;
   logic [DEPTH-1:0] valid;
   logic             busy1, busy2;

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         logic [AW-1:0] off;
         off      = AW'(i) - rd_ptr_q;
         valid[i] = CW'(off) < cnt_q;
      end
   end

   always_comb begin
      fifo_ne  = (cnt_q != '0);
      stall    = (starve_q == SW'(STARVE_MAX)) && fifo_ne;
      alu_ok   = !stall && bus.alu_we && (bus.alu_wa != 5'd0);
      pop      = fifo_ne && (stall || !alu_ok);
      // ld_ready is based on the count before this cycle's pop.
      push_acc = bus.ld_valid && (cnt_q != CW'(DEPTH));
      // A load to x0 is accepted but never stored.
      push     = push_acc && (bus.ld_wa != 5'd0);

      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);

      if (pop || !fifo_ne)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + SW'(1);
      else
         starve_d = starve_q;

      wb_we_d = 1'b0;
      wb_wa_d = wb_wa_q;
      wb_wd_d = wb_wd_q;
      if (pop) begin
         // A killed head is discarded. The FIFO still pops, but nothing is written.
         if (!kill_q[rd_ptr_q]) begin
            wb_we_d = 1'b1;
            wb_wa_d = wa_q[rd_ptr_q];
            wb_wd_d = wd_q[rd_ptr_q];
         end
      end else if (alu_ok) begin
         wb_we_d = 1'b1;
         wb_wa_d = bus.alu_wa;
         wb_wd_d = bus.alu_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         wa_q[wr_ptr_q] <= bus.ld_wa;
         wd_q[wr_ptr_q] <= bus.ld_wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kill_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         wb_we_q  <= 1'b0;
         wb_wa_q  <= '0;
         wb_wd_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // The slot being written is never live (there is no push when full),
            // so a newly pushed load starts unkilled even if the ALU hits its address.
            if (push && (wr_ptr_q == AW'(i)))
               kill_q[i] <= 1'b0;
            else if (alu_ok && valid[i] && (wa_q[i] == bus.alu_wa))
               kill_q[i] <= 1'b1;
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         wb_we_q  <= wb_we_d;
         wb_wa_q  <= wb_wa_d;
         wb_wd_q  <= wb_wd_d;
      end
   end

   // Pending-write lookup for decode. Only committed sources count, not alu_*.
   always_comb begin
      busy1 = wb_we_q && (wb_wa_q == bus.qa1);
      busy2 = wb_we_q && (wb_wa_q == bus.qa2);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && !kill_q[i] && (wa_q[i] == bus.qa1)) busy1 = 1'b1;
         if (valid[i] && !kill_q[i] && (wa_q[i] == bus.qa2)) busy2 = 1'b1;
      end
   end

   assign bus.q_busy1    = (bus.qa1 != 5'd0) && busy1;
   assign bus.q_busy2    = (bus.qa2 != 5'd0) && busy2;
   assign bus.pipe_stall = stall;
   assign bus.ld_ready   = (cnt_q != CW'(DEPTH));
   assign bus.fifo_count = cnt_q;
   assign bus.wb_we      = wb_we_q;
   assign bus.wb_wa      = wb_wa_q;
   assign bus.wb_wd      = wb_wd_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. Directed scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_wb_arbiter;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_if #(.DEPTH(DEPTH)) bus();

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          kill;
   } ent_t;

   // Reference model state
   ent_t        mq[$];
   int          m_starve;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   int          n_chk, n_fail;
   logic [31:0] rf [32];
   bit          obs_stall, obs_rdy, obs_b1, obs_b2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_busy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      foreach (mq[i]) if (!mq[i].kill && mq[i].wa == a) return 1'b1;
      return m_we && (m_wa == a);
   endfunction

   function automatic void m_reset();
      mq.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
   endfunction

   // One clock of traffic. Called at a negedge; returns at the next negedge.
   task automatic step(input bit awe, input logic [4:0] awa, input logic [31:0] awd,
                       input bit lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic [4:0] q1, input logic [4:0] q2);
      bit   stall, rdy, alu_ok, popped;
      int   sz0;
      ent_t e;
      bus.alu_we = awe; bus.alu_wa = awa; bus.alu_wd = awd;
      bus.ld_valid = lv; bus.ld_wa = lwa; bus.ld_wd = lwd;
      bus.qa1 = q1; bus.qa2 = q2;
      #1;
      sz0   = mq.size();
      stall = (m_starve == STARVE_MAX) && (sz0 != 0);
      rdy   = (sz0 != DEPTH);
      chk("pipe_stall", 32'(bus.pipe_stall), 32'(stall));
      chk("ld_ready",   32'(bus.ld_ready),   32'(rdy));
      chk("q_busy1",    32'(bus.q_busy1),    32'(m_busy(q1)));
      chk("q_busy2",    32'(bus.q_busy2),    32'(m_busy(q2)));
      obs_stall = bus.pipe_stall; obs_rdy = bus.ld_ready;
      obs_b1 = bus.q_busy1; obs_b2 = bus.q_busy2;

      // Selection rules, evaluated on the pre-edge state
      alu_ok = !stall && awe && (awa != 5'd0);
      popped = 1'b0;
      if (sz0 != 0 && (stall || !alu_ok)) begin
         e = mq.pop_front();
         popped = 1'b1;
         m_we = !e.kill;
         if (!e.kill) begin m_wa = e.wa; m_wd = e.wd; end
      end else if (alu_ok) begin
         m_we = 1'b1; m_wa = awa; m_wd = awd;
         foreach (mq[i]) if (mq[i].wa == awa) mq[i].kill = 1'b1;
      end else begin
         m_we = 1'b0;
      end
      if (lv && rdy && lwa != 5'd0) mq.push_back('{wa: lwa, wd: lwd, kill: 1'b0});
      if (popped || sz0 == 0) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;

      @(posedge clk);
      @(negedge clk);
      chk("wb_we", 32'(bus.wb_we), 32'(m_we));
      if (m_we) begin
         chk("wb_wa", 32'(bus.wb_wa), 32'(m_wa));
         chk("wb_wd", bus.wb_wd, m_wd);
      end
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      if (bus.wb_we) rf[bus.wb_wa] = bus.wb_wd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int first_stall, nstall, p;
      bit rdy_at[64];
      n_chk = 0; n_fail = 0;
      foreach (rf[i]) rf[i] = '0;
      m_reset();
      bus.alu_we = 0; bus.alu_wa = 0; bus.alu_wd = 0;
      bus.ld_valid = 0; bus.ld_wa = 0; bus.ld_wd = 0;
      bus.qa1 = 0; bus.qa2 = 0;
      repeat (2) @(negedge clk);
      chk("rst wb_we", 32'(bus.wb_we), 0);
      chk("rst wb_wa", 32'(bus.wb_wa), 0);
      chk("rst wb_wd", bus.wb_wd, 0);
      chk("rst fifo_count", 32'(bus.fifo_count), 0);
      chk("rst pipe_stall", 32'(bus.pipe_stall), 0);
      chk("rst ld_ready", 32'(bus.ld_ready), 1);
      rst_n = 1'b1;

      // A single load is pushed and then drains on the following idle cycle.
      step(0, 0, 0, 1, 5'd5, 32'hAAAA_0001, 5'd5, 0);
      chk("s1 count after push", 32'(bus.fifo_count), 1);
      step(0, 0, 0, 0, 0, 0, 5'd5, 0);
      chk("s1 busy5 queued", 32'(obs_b1), 1);
      chk("s1 wb_we", 32'(bus.wb_we), 1);
      chk("s1 wb_wa", 32'(bus.wb_wa), 5);
      chk("s1 wb_wd", bus.wb_wd, 32'hAAAA_0001);
      chk("s1 count drained", 32'(bus.fifo_count), 0);

      // The ALU writes every cycle, so three loads wait for forced drains.
      first_stall = -1; nstall = 0;
      for (int k = 0; k < 35; k++) begin
         step(1, 5'd1, 32'(k), k < 3, 5'(10 + k), 32'h100 + 32'(k), 0, 0);
         if (obs_stall) begin
            nstall++;
            if (first_stall < 0) first_stall = k;
         end
      end
      chk("s2 first stall cycle", 32'(first_stall), 9);
      chk("s2 stall count", 32'(nstall), 3);
      chk("s2 fifo empty", 32'(bus.fifo_count), 0);
      chk("s2 rf x12", rf[12], 32'h102);

      // The FIFO fills behind a busy ALU, and a fifth load is refused.
      for (int k = 0; k < 40; k++) begin
         step(1, 5'd2, 32'h2000 + 32'(k), k < 5, 5'(20 + k), 32'h200 + 32'(k), 0, 0);
         rdy_at[k] = obs_rdy;
         if (k == 4) chk("s3 count full", 32'(bus.fifo_count), 4);
      end
      chk("s3 ld_ready full", 32'(rdy_at[4]), 0);
      chk("s3 ld_ready on pop cycle", 32'(rdy_at[9]), 0);
      chk("s3 ld_ready after pop", 32'(rdy_at[10]), 1);
      chk("s3 rf x24 untouched", rf[24], 0);

      // WAW: an ALU write to x7 overtakes the buffered load to x7.
      step(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 5'd7, 0);
      step(1, 5'd7, 32'h11, 0, 0, 0, 5'd7, 0);
      chk("s4 busy7 queued", 32'(obs_b1), 1);
      step(0, 0, 0, 0, 0, 0, 5'd7, 0);
      chk("s4 busy7 alu in wb", 32'(obs_b1), 1);
      chk("s4 killed pop no write", 32'(bus.wb_we), 0);
      step(0, 0, 0, 0, 0, 0, 5'd7, 0);
      chk("s4 busy7 cleared", 32'(obs_b1), 0);
      chk("s4 rf x7", rf[7], 32'h11);

      // Writes to x0 from either source are ignored.
      step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
      chk("s5 busy0", 32'(obs_b1), 0);
      chk("s5 wb_we", 32'(bus.wb_we), 0);
      chk("s5 count", 32'(bus.fifo_count), 0);

      // Reset while three loads are queued behind a busy ALU.
      for (int k = 0; k < 3; k++) step(1, 5'd1, 32'h9, 1, 5'(13 + k), 32'h300, 0, 0);
      chk("s6 queued", 32'(bus.fifo_count), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("s6 rst wb_we", 32'(bus.wb_we), 0);
      chk("s6 rst count", 32'(bus.fifo_count), 0);
      chk("s6 rst ld_ready", 32'(bus.ld_ready), 1);
      m_reset();
      bus.alu_we = 0; bus.ld_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0, 5'd13, 5'd15);
         chk("s6 no stale write", 32'(bus.wb_we), 0);
      end

      // Randomized traffic, in phases of heavy, medium and light ALU load.
      for (int i = 0; i < 3000; i++) begin
         p = (i / 200) % 3 == 0 ? 92 : ((i / 200) % 3 == 1 ? 50 : 10);
         step($urandom_range(99) < p, 5'($urandom_range(7)), $urandom,
              $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom,
              5'($urandom_range(7)), 5'($urandom_range(7)));
         if (i == 1500) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rand rst count", 32'(bus.fifo_count), 0);
            m_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
